// File: rtl/word_select_seq.sv
// Word selector with synchronized switches, manual/auto-scan/hold modes and a registered output.
// Optional select debounce filter: define WORD_SELECT_DEBOUNCE_EN.
module word_select_seq #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SCAN_DIV = 50000000,
    parameter int DEBOUNCE = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] words,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      scan_mode,
    input  logic                      freeze,
    output logic [WIDTH-1:0]          mux_out,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      changed
);

    localparam int                STEP_W    = $clog2(SCAN_DIV);
    localparam logic [SEL_W:0]    CH_LIMIT  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(CHANNELS - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {MANUAL, SCAN, HOLD} state_t;

    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  sel_s1_reg, sel_s2_reg;
    logic              scan_s1_reg, scan_s2_reg;
    logic              freeze_s1_reg, freeze_s2_reg;
    logic [SEL_W-1:0]  cur_sel_reg, cur_sel_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic [WIDTH-1:0]  mux_out_reg, mux_out_next;
    logic              changed_reg;
    logic              sel_accept;
    logic [WIDTH-1:0]  sel_word;

    logic [WIDTH-1:0] word_arr [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign word_arr[gi] = words[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef WORD_SELECT_DEBOUNCE_EN
    localparam int DCNT_W = $clog2(DEBOUNCE + 1);

    logic [SEL_W-1:0]  cand_reg;
    logic [DCNT_W-1:0] dcnt_reg, dcnt_next, run_len;

    // run_len counts consecutive manual edges on which the synced select held its value
    always_comb begin
        run_len = DCNT_W'(1);
        if (sel_s2_reg == cand_reg) begin
            run_len = (dcnt_reg == DCNT_W'(DEBOUNCE)) ? dcnt_reg : dcnt_reg + 1'b1;
        end
        sel_accept = (sel_s2_reg != cur_sel_reg) && (run_len == DCNT_W'(DEBOUNCE));
        dcnt_next  = (state_next == MANUAL) ? run_len : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_reg <= '0;
            dcnt_reg <= '0;
        end else begin
            cand_reg <= sel_s2_reg;
            dcnt_reg <= dcnt_next;
        end
    end
`else
    // DEBOUNCE only shapes timing when the filter is built; it is always >= 1
    always_comb begin
        sel_accept = (sel_s2_reg != cur_sel_reg) && (DEBOUNCE > 0);
    end
`endif

    always_comb begin
        state_next   = freeze_s2_reg ? HOLD : (scan_s2_reg ? SCAN : MANUAL);
        cur_sel_next = cur_sel_reg;
        step_next    = step_reg;
        mux_out_next = mux_out_reg;
        sel_word     = '0;

        case (state_next)
            MANUAL: begin
                if (sel_accept) begin
                    cur_sel_next = sel_s2_reg;
                end
            end
            SCAN: begin
                if (state_reg != SCAN) begin
                    step_next = '0;
                end else if (step_reg == LAST_STEP) begin
                    step_next    = '0;
                    cur_sel_next = (cur_sel_reg >= LAST_SEL) ? '0 : cur_sel_reg + 1'b1;
                end else begin
                    step_next = step_reg + 1'b1;
                end
            end
            default: ;
        endcase

        // Out-of-range manual selects read as zero
        if ({1'b0, cur_sel_next} < CH_LIMIT) begin
            sel_word = word_arr[cur_sel_next];
        end
        if (state_next != HOLD) begin
            mux_out_next = sel_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_s1_reg    <= '0;
            sel_s2_reg    <= '0;
            scan_s1_reg   <= 1'b0;
            scan_s2_reg   <= 1'b0;
            freeze_s1_reg <= 1'b0;
            freeze_s2_reg <= 1'b0;
            state_reg     <= MANUAL;
            cur_sel_reg   <= '0;
            step_reg      <= '0;
            mux_out_reg   <= '0;
            changed_reg   <= 1'b0;
        end else begin
            sel_s1_reg    <= sel;
            sel_s2_reg    <= sel_s1_reg;
            scan_s1_reg   <= scan_mode;
            scan_s2_reg   <= scan_s1_reg;
            freeze_s1_reg <= freeze;
            freeze_s2_reg <= freeze_s1_reg;
            state_reg     <= state_next;
            cur_sel_reg   <= cur_sel_next;
            step_reg      <= step_next;
            mux_out_reg   <= mux_out_next;
            changed_reg   <= (cur_sel_next != cur_sel_reg);
        end
    end

    assign mux_out = mux_out_reg;
    assign cur_sel = cur_sel_reg;
    assign changed = changed_reg;

endmodule

// File: tb/tb_word_select_seq.sv
// Randomized bench for word_select_seq: an 8-channel and a 6-channel instance share stimulus
// and are checked every cycle against a behavioural model, plus directed literal checks.
module tb_word_select_seq;

    localparam int W  = 32;
    localparam int SD = 4;
    localparam int DB = 4;
`ifdef WORD_SELECT_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
    localparam int LAT    = 2 + DB;
`else
    localparam bit DEB_EN = 1'b0;
    localparam int LAT    = 3;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [8*W-1:0] words;
    logic [2:0]   sel;
    logic         scan_mode, freeze;
    logic [W-1:0] mux8, mux6;
    logic [2:0]   cur8, cur6;
    logic         chg8, chg6;

    int tests = 0;
    int fails = 0;
    int chg_cnt = 0;

    word_select_seq #(.WIDTH(W), .CHANNELS(8), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut8 (
        .clk(clk), .reset_n(reset_n), .words(words), .sel(sel),
        .scan_mode(scan_mode), .freeze(freeze),
        .mux_out(mux8), .cur_sel(cur8), .changed(chg8)
    );

    word_select_seq #(.WIDTH(W), .CHANNELS(6), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut6 (
        .clk(clk), .reset_n(reset_n), .words(words[6*W-1:0]), .sel(sel),
        .scan_mode(scan_mode), .freeze(freeze),
        .mux_out(mux6), .cur_sel(cur6), .changed(chg6)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp, input bit quiet);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end else if (!quiet) begin
            $display("ok   %s = %0h", nm, act);
        end
    endtask

    // Behavioural model: modes 0=manual 1=scan 2=hold; synced input = raw value two edges ago
    int           p1_sel = 0, p2_sel = 0;
    bit           p1_scan = 0, p2_scan = 0, p1_frz = 0, p2_frz = 0;
    int           m_cur [2]  = '{0, 0};
    logic [W-1:0] m_out [2]  = '{0, 0};
    bit           m_chg [2]  = '{0, 0};
    int           m_mode [2] = '{0, 0};
    int           m_age [2]  = '{0, 0};
    int           m_run [2]  = '{0, 0};
    int           m_pss [2]  = '{0, 0};

    task automatic model_reset();
        p1_sel = 0; p2_sel = 0; p1_scan = 0; p2_scan = 0; p1_frz = 0; p2_frz = 0;
        for (int k = 0; k < 2; k++) begin
            m_cur[k] = 0; m_out[k] = '0; m_chg[k] = 0;
            m_mode[k] = 0; m_age[k] = 0; m_run[k] = 0; m_pss[k] = 0;
        end
    endtask

    task automatic model_step();
        int ss, ch, mode, nc;
        bit sm, sf;
        ss = p2_sel; sm = p2_scan; sf = p2_frz;
        p2_sel = p1_sel; p2_scan = p1_scan; p2_frz = p1_frz;
        p1_sel = int'(sel); p1_scan = scan_mode; p1_frz = freeze;
        for (int k = 0; k < 2; k++) begin
            ch   = (k == 0) ? 8 : 6;
            mode = sf ? 2 : (sm ? 1 : 0);
            nc   = m_cur[k];
            m_run[k] = (mode == 0) ? ((ss == m_pss[k]) ? m_run[k] + 1 : 1) : 0;
            m_pss[k] = ss;
            if (mode == 0) begin
                if (ss != nc && (!DEB_EN || m_run[k] >= DB)) nc = ss;
            end else if (mode == 1) begin
                if (m_mode[k] != 1) begin
                    m_age[k] = 0;
                end else begin
                    m_age[k]++;
                    if (m_age[k] % SD == 0) nc = (m_cur[k] >= ch - 1) ? 0 : m_cur[k] + 1;
                end
            end
            m_chg[k] = (nc != m_cur[k]);
            m_cur[k] = nc;
            if (mode != 2) m_out[k] = (nc < ch) ? words[nc*W +: W] : '0;
            m_mode[k] = mode;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) model_reset();
        else model_step();
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        check("mux8", 64'(mux8), 64'(m_out[0]), 1'b1);
        check("cur8", 64'(cur8), 64'(m_cur[0]), 1'b1);
        check("chg8", 64'(chg8), 64'(m_chg[0]), 1'b1);
        check("mux6", 64'(mux6), 64'(m_out[1]), 1'b1);
        check("cur6", 64'(cur6), 64'(m_cur[1]), 1'b1);
        check("chg6", 64'(chg6), 64'(m_chg[1]), 1'b1);
        if (chg8) chg_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_slot();
        @(negedge clk);
        #1;
    endtask

    task automatic init_words();
        for (int i = 0; i < 8; i++) words[i*W +: W] = 32'h1000_0000 + 32'(i);
    endtask

    initial begin
        int snap, wi;
        init_words();
        sel = 3'd0; scan_mode = 1'b0; freeze = 1'b0;

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check("reset mux_out", 64'(mux8), 64'h0, 1'b0);
        check("reset cur_sel", 64'(cur8), 64'h0, 1'b0);
        check("reset changed", 64'(chg8), 64'h0, 1'b0);
        tick(3);
        drive_slot();
        reset_n = 1'b1;

        // Idle at sel=0
        tick(6);
        check("idle mux_out", 64'(mux8), 64'h1000_0000, 1'b0);
        check("idle cur_sel", 64'(cur8), 64'h0, 1'b0);
        check("idle changed pulses", 64'(chg_cnt), 64'h0, 1'b0);

        // Manual change 0 -> 5
        drive_slot();
        sel = 3'd5;
        tick(LAT - 1);
        check("sel5 before latency", 64'(cur8), 64'h0, 1'b0);
        tick(1);
        check("sel5 cur_sel", 64'(cur8), 64'h5, 1'b0);
        check("sel5 mux_out", 64'(mux8), 64'h1000_0005, 1'b0);
        check("sel5 changed", 64'(chg8), 64'h1, 1'b0);
        tick(1);
        check("sel5 changed drop", 64'(chg8), 64'h0, 1'b0);

        // Two-cycle glitch to 3
        snap = chg_cnt;
        drive_slot();
        sel = 3'd3;
        drive_slot();
        drive_slot();
        sel = 3'd5;
        tick(12);
        check("glitch cur_sel", 64'(cur8), 64'h5, 1'b0);
`ifdef WORD_SELECT_DEBOUNCE_EN
        check("glitch no pulse", 64'(chg_cnt - snap), 64'h0, 1'b0);
`endif

        // Auto-scan from 6
        drive_slot();
        sel = 3'd6;
        tick(LAT + 2);
        check("pre-scan cur_sel", 64'(cur8), 64'h6, 1'b0);
        drive_slot();
        scan_mode = 1'b1;
        tick(6);
        check("scan hold 6", 64'(cur8), 64'h6, 1'b0);
        tick(1);
        check("scan step 7", 64'(cur8), 64'h7, 1'b0);
        check("scan step 7 pulse", 64'(chg8), 64'h1, 1'b0);
        tick(4);
        check("scan step 0", 64'(cur8), 64'h0, 1'b0);
        check("scan step 0 pulse", 64'(chg8), 64'h1, 1'b0);
        tick(4);
        check("scan step 1", 64'(cur8), 64'h1, 1'b0);
        check("scan step 1 mux", 64'(mux8), 64'h1000_0001, 1'b0);
        drive_slot();
        scan_mode = 1'b0;
        sel = 3'd2;
        for (int i = 0; i < 20 && cur8 !== 3'd2; i++) tick(1);
        check("scan exit cur_sel", 64'(cur8), 64'h2, 1'b0);

        // Freeze holds output
        drive_slot();
        freeze = 1'b1;
        tick(5);
        drive_slot();
        words[2*W +: W] = 32'hDEAD_BEEF;
        tick(3);
        check("hold mux_out", 64'(mux8), 64'h1000_0002, 1'b0);
        drive_slot();
        freeze = 1'b0;
        tick(2);
        check("unfreeze still held", 64'(mux8), 64'h1000_0002, 1'b0);
        tick(1);
        check("unfreeze mux_out", 64'(mux8), 64'hDEAD_BEEF, 1'b0);

        // Out-of-range select on the 6-channel instance
        drive_slot();
        sel = 3'd7;
        tick(LAT + 1);
        check("ch6 cur_sel 7", 64'(cur6), 64'h7, 1'b0);
        check("ch6 mux zero", 64'(mux6), 64'h0, 1'b0);
        check("ch8 mux 7", 64'(mux8), 64'h1000_0007, 1'b0);
        drive_slot();
        scan_mode = 1'b1;
        tick(7);
        check("ch6 scan wraps to 0", 64'(cur6), 64'h0, 1'b0);
        check("ch6 scan mux", 64'(mux6), 64'h1000_0000, 1'b0);
        tick(2);
        drive_slot();
        reset_n = 1'b0;
        #1;
        check("midscan reset mux8", 64'(mux8), 64'h0, 1'b0);
        check("midscan reset cur8", 64'(cur8), 64'h0, 1'b0);
        check("midscan reset chg8", 64'(chg8), 64'h0, 1'b0);
        check("midscan reset mux6", 64'(mux6), 64'h0, 1'b0);
        check("midscan reset cur6", 64'(cur6), 64'h0, 1'b0);
        tick(2);
        init_words();
        sel = 3'd0; scan_mode = 1'b0;
        drive_slot();
        reset_n = 1'b1;

        // Randomized phase, checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            drive_slot();
            reset_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 7) == 0)  sel = 3'($urandom);
            if ($urandom_range(0, 39) == 0) scan_mode = ~scan_mode;
            if ($urandom_range(0, 59) == 0) freeze = ~freeze;
            if ($urandom_range(0, 3) == 0) begin
                wi = $urandom_range(0, 7);
                words[wi*W +: W] = $urandom;
            end
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
